shift_deserializer: RTL and testbench
=====================================

SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..32).
REQ-002 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port serial_in  input  1  is the serial data bit, MSB of each word first.
REQ-005 Port bit_valid  input  1  SHALL qualify serial_in; a bit is sampled only on edges where bit_valid=1.
REQ-006 Port sync  input  1  SHALL mark, when high together with bit_valid, the first (MSB) bit of a new word.
REQ-007 Port data_out  output  WIDTH  is the completed parallel word.
REQ-008 Port out_valid  output  1  SHALL be high while data_out holds an unconsumed word.
REQ-009 Port out_ready  input  1  is consumer acceptance; a transfer occurs on edges where out_valid=1 and out_ready=1.
REQ-010 Port overrun  output  1  is the sticky flag for a word lost because the holding register was full.
REQ-011 Port frame_err  output  1  is the sticky flag for a sync received mid-word.
REQ-012 Port clear_err  input  1  SHALL synchronously clear overrun and frame_err.

Function
REQ-013 The FSM SHALL have two states: IDLE (waiting for sync) and RECV (collecting bits).
REQ-014 In IDLE, an edge with sync=1 and bit_valid=1 SHALL load serial_in into shift-register bit 0, set bit count to 1 and enter RECV.
- In IDLE, bit_valid=1 with sync=0 SHALL be ignored.
REQ-015 In RECV, each edge with bit_valid=1 and sync=0 SHALL perform shreg <= {shreg[WIDTH-2:0], serial_in} and increment the count.
REQ-016 When the sampled bit is the WIDTH-th bit of the word, the assembled word SHALL be offered to the holding register on that same edge, and the FSM SHALL return to IDLE.
REQ-017 Latency: out_valid and data_out SHALL be visible immediately after the edge that samples the last bit (0 extra cycles).
REQ-018 The holding register SHALL load the word if out_valid=0, or if out_valid=1 and out_ready=1 on that same edge (simultaneous consume-and-load, no overrun).
REQ-019 If out_valid=1 and out_ready=0 when a word completes, the new word SHALL be dropped, data_out SHALL remain unchanged, and overrun SHALL be set.
REQ-020 A handshake with no completing word SHALL clear out_valid on that edge; data_out SHALL hold its last value.
REQ-021 data_out SHALL be stable while out_valid=1 and out_ready=0.
REQ-022 In RECV, sync=1 with bit_valid=1 SHALL discard the partial word, set frame_err, and restart the word with this bit as the MSB (count=1, stay in RECV).
REQ-023 bit_valid=0 SHALL freeze the shift register, count and FSM state; gaps of any length SHALL be permitted.
REQ-024 clear_err=1 SHALL take priority over a same-edge set of either flag, so the flag reads 0 after that edge.
REQ-025 The count SHALL be ceil(log2(WIDTH+1)) bits wide and never exceed WIDTH.

Reset
REQ-026 rst=0 SHALL immediately force: FSM to IDLE, count 0, shreg 0, data_out 0, out_valid 0, overrun 0, frame_err 0.
REQ-027 Reset asserted mid-word SHALL discard the partial word; no word SHALL be delivered for it after release.
REQ-028 The first word after reset release SHALL require a fresh sync.

Structure
REQ-029 Package shift_pkg SHALL hold the FSM state encoding (IDLE=0, RECV=1) and the default word width constant (4).
REQ-030 The output holding register plus its valid/ready logic SHALL be one sub-module, rx_hold_buf; the FSM, counter and shreg SHALL stay in the top module.

Verification (WIDTH=4)
REQ-031 Bits 1,0,1,1 with sync on the first and bit_valid every cycle, out_ready=1 -> data_out=4'b1011 and out_valid=1 right after the 4th edge.
REQ-032 Word 4'hA, then 4'h5 with out_ready=0 throughout -> data_out stays 4'hA, out_valid=1, overrun=1; then clear_err -> overrun=0.
REQ-033 4'h3 completes on the same edge that out_ready=1 accepts pending 4'hC -> data_out=4'h3, out_valid=1, overrun=0.
REQ-034 Two bits of a word, then sync with bits 1,1,1,0 -> frame_err=1 and data_out=4'hE.
REQ-035 Bits 1,0,1,1 with bit_valid=0 for 3 cycles between each bit -> data_out=4'hB, out_valid only after the 4th valid bit.
REQ-036 rst=0 after 3 bits, released, then a full 4'h6 with sync -> all outputs 0 during reset, then only 4'h6 delivered.

Source files
------------

// File: rtl/shift_deserializer_pkg.sv
// Shared definitions for the serial-to-parallel deserializer.
//   state_t        : receive FSM state encoding (IDLE=0, RECV=1)
//   DEFAULT_WIDTH  : default parallel word width
//   cnt_width()    : bits needed to hold a bit count of 0..width
package shift_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_deserializer_if.sv
// Serial input / parallel output bundle of the deserializer.
//   serial_in, bit_valid, sync : serial bit stream (MSB first, sync marks MSB)
//   data_out, out_valid        : completed word and its valid flag
//   out_ready                  : consumer acceptance
//   overrun, frame_err         : sticky error flags
//   clear_err                  : synchronous clear for both error flags
// master = stream source / consumer side, slave = deserializer side.
interface shift_deserializer_if import shift_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             serial_in;
  logic             bit_valid;
  logic             sync;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             frame_err;
  logic             clear_err;

  modport master (
    output serial_in, bit_valid, sync, out_ready, clear_err,
    input  data_out, out_valid, overrun, frame_err
  );

  modport slave (
    input  serial_in, bit_valid, sync, out_ready, clear_err,
    output data_out, out_valid, overrun, frame_err
  );
endinterface

// File: rtl/shift_deserializer_rx_hold_buf.sv
// Output holding register with valid/ready handshake.
//   clk, rst   : clock, asynchronous active-low reset
//   i_load     : a completed word is offered this edge
//   i_word     : the completed word
//   i_ready    : consumer acceptance
//   o_data     : held word (keeps its value after being consumed)
//   o_valid    : o_data holds an unconsumed word
//   o_drop     : offered word is discarded because the register is full
module rx_hold_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_drop
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             w_take;
  logic             w_consume;

  // A consume on the same edge frees the slot, so load-and-consume is legal.
  assign w_consume = r_valid & i_ready;
  assign w_take    = i_load & (~r_valid | i_ready);
  assign o_drop    = i_load & r_valid & ~i_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (w_take) begin
      r_data  <= i_word;
      r_valid <= 1'b1;
    end else if (w_consume) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel deserializer, MSB first, framed by a sync marker.
//   clk : clock (rising edge)
//   rst : asynchronous active-low reset
//   bus : shift_deserializer_if slave (serial in, parallel word out,
//         valid/ready handshake, sticky overrun / frame_err, clear_err)
module shift_deserializer import shift_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                 clk,
  input logic                 rst,
  shift_deserializer_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_overrun;
  logic             r_frame_err;

  logic             w_restart;
  logic             w_word_done;
  logic             w_drop;
  logic [WIDTH-1:0] w_word;

  assign w_restart   = bus.bit_valid & bus.sync & (r_state == RECV);
  // Completion is decided combinationally so the word reaches the holding
  // register on the very edge that samples its last bit.
  assign w_word_done = bus.bit_valid & ~bus.sync & (r_state == RECV) &
                       (r_cnt == CNT_W'(WIDTH - 1));
  assign w_word      = {r_shreg[WIDTH-2:0], bus.serial_in};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
    end else if (bus.bit_valid) begin
      unique case (r_state)
        IDLE: begin
          if (bus.sync) begin
            r_shreg <= {{(WIDTH-1){1'b0}}, bus.serial_in};
            r_cnt   <= CNT_W'(1);
            r_state <= RECV;
          end
        end
        RECV: begin
          if (bus.sync) begin
            r_shreg <= {{(WIDTH-1){1'b0}}, bus.serial_in};
            r_cnt   <= CNT_W'(1);
          end else if (w_word_done) begin
            r_shreg <= w_word;
            r_cnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_shreg <= w_word;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sticky flags; clear_err wins over a same-edge set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (bus.clear_err) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_drop)    r_overrun   <= 1'b1;
      if (w_restart) r_frame_err <= 1'b1;
    end
  end

  rx_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_word_done),
    .i_word  (w_word),
    .i_ready (bus.out_ready),
    .o_data  (bus.data_out),
    .o_valid (bus.out_valid),
    .o_drop  (w_drop)
  );

  assign bus.overrun   = r_overrun;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_shift_deserializer.sv
module tb_shift_deserializer;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  shift_deserializer_if #(.WIDTH(W)) bus ();

  shift_deserializer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: bits of the word in progress kept as a queue.
  bit         m_bits[$];
  logic [W-1:0] m_data;
  logic       m_valid;
  logic       m_ov;
  logic       m_fe;

  task automatic model_reset();
    m_bits.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ov    = 1'b0;
    m_fe    = 1'b0;
  endtask

  task automatic model_edge(input logic si, bv, sy, rdy, clr);
    logic [W-1:0] word;
    bit done, ov_set, fe_set;
    done = 0; ov_set = 0; fe_set = 0; word = '0;
    if (bv) begin
      if (sy) begin
        if (m_bits.size() != 0) fe_set = 1;
        m_bits.delete();
        m_bits.push_back(si);
      end else if (m_bits.size() != 0) begin
        m_bits.push_back(si);
        if (m_bits.size() == W) begin
          for (int i = 0; i < W; i++) word = (word << 1) | W'(m_bits[i]);
          m_bits.delete();
          done = 1;
        end
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_data  = word;
        m_valid = 1'b1;
      end else begin
        ov_set = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    m_ov = clr ? 1'b0 : (m_ov | ov_set);
    m_fe = clr ? 1'b0 : (m_fe | fe_set);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".data_out"},  32'(bus.data_out),  32'(m_data));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(m_valid));
    chk({tag, ".overrun"},   32'(bus.overrun),   32'(m_ov));
    chk({tag, ".frame_err"}, 32'(bus.frame_err), 32'(m_fe));
  endtask

  task automatic cyc(input logic si, bv, sy, rdy, clr, input string tag);
    @(negedge clk);
    bus.serial_in = si;
    bus.bit_valid = bv;
    bus.sync      = sy;
    bus.out_ready = rdy;
    bus.clear_err = clr;
    @(posedge clk);
    model_edge(si, bv, sy, rdy, clr);
    #1;
    chk_model(tag);
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic rdy_early, rdy_last, input string tag);
    logic [W-1:0] v;
    v = w;
    for (int i = W - 1; i >= 0; i--)
      cyc(v[i], 1'b1, (i == W - 1), (i == 0) ? rdy_last : rdy_early, 1'b0, tag);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".data_out"},  32'(bus.data_out),  32'h0);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'h0);
    chk({tag, ".overrun"},   32'(bus.overrun),   32'h0);
    chk({tag, ".frame_err"}, 32'(bus.frame_err), 32'h0);
  endtask

  initial begin
    logic [W-1:0] gw;
    bus.serial_in = 1'b0;
    bus.bit_valid = 1'b0;
    bus.sync      = 1'b0;
    bus.out_ready = 1'b0;
    bus.clear_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // bit_valid without sync in IDLE is ignored
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "idle_nosync");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "idle_nosync");

    // 1,0,1,1 -> 4'b1011 right after the 4th edge
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "w1011");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "w1011");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "w1011");
    chk("w1011.pre_valid", 32'(bus.out_valid), 32'h0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "w1011");
    chk("w1011.data", 32'(bus.data_out), 32'hB);
    chk("w1011.valid", 32'(bus.out_valid), 32'h1);

    // handshake without a new word clears valid, data holds
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "drain");
    chk("drain.valid", 32'(bus.out_valid), 32'h0);
    chk("drain.data", 32'(bus.data_out), 32'hB);

    // A then 5 with out_ready low -> overrun, A kept
    send_word(4'hA, 1'b0, 1'b0, "ovr_a");
    send_word(4'h5, 1'b0, 1'b0, "ovr_5");
    chk("ovr.data", 32'(bus.data_out), 32'hA);
    chk("ovr.valid", 32'(bus.out_valid), 32'h1);
    chk("ovr.flag", 32'(bus.overrun), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ovr_clr");
    chk("ovr_clr.flag", 32'(bus.overrun), 32'h0);

    // C pending, 3 completes on the edge C is consumed
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "drain_a");
    send_word(4'hC, 1'b0, 1'b0, "cl_c");
    send_word(4'h3, 1'b0, 1'b1, "cl_3");
    chk("cl.data", 32'(bus.data_out), 32'h3);
    chk("cl.valid", 32'(bus.out_valid), 32'h1);
    chk("cl.ovr", 32'(bus.overrun), 32'h0);

    // two bits then a fresh sync -> frame_err, word E
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "fe_part");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "fe_part");
    send_word(4'hE, 1'b1, 1'b1, "fe_e");
    chk("fe.flag", 32'(bus.frame_err), 32'h1);
    chk("fe.data", 32'(bus.data_out), 32'hE);

    // clear_err beats a same-edge frame error
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "clrpri");
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, "clrpri");
    chk("clrpri.fe", 32'(bus.frame_err), 32'h0);

    // 1,0,1,1 separated by 3-cycle gaps
    gw = 4'hB;
    for (int i = W - 1; i >= 0; i--) begin
      cyc(gw[i], 1'b1, (i == W - 1), 1'b1, 1'b0, "gap");
      if (i != 0) begin
        chk("gap.valid_early", 32'(bus.out_valid), 32'h0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gap_idle");
      end
    end
    chk("gap.data", 32'(bus.data_out), 32'hB);
    chk("gap.valid", 32'(bus.out_valid), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "gap_drain");

    // reset mid-word
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "rst_part");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "rst_part");
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "rst_part");
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    chk_all_zero("rst_async");
    @(posedge clk);
    #1;
    chk_all_zero("rst_held");
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "post_rst_orphan");
    chk("post_rst.valid", 32'(bus.out_valid), 32'h0);
    send_word(4'h6, 1'b1, 1'b1, "post_rst_6");
    chk("post_rst.data", 32'(bus.data_out), 32'h6);
    chk("post_rst.valid6", 32'(bus.out_valid), 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "post_rst_drain");
    chk("post_rst.once", 32'(bus.out_valid), 32'h0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom_range(0, 1)),
          ($urandom_range(0, 9) < 7),
          ($urandom_range(0, 9) < 2),
          ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 19) == 0),
          "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
